gate_bist_ctrl: RTL

Built-in self-test sequencer for the dual 4-input gate block (sections p1 and p2, inputs a..d, output y).
- Sweeps all 256 combinations of the 8 gate inputs and samples p1y/p2y after a programmable settle time.
- Compares each sample against the expected 4-input AND/NAND result and reports pass/fail, per-section error counts and the first failing vector.
- Sits between a top-level test controller (start/done handshake) and the gate instance.

---
 rtl/gate_bist_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/gate_bist_ctrl.sv
// rtl/gate_bist_ctrl.sv - BIST sweep sequencer for the dual 4-input gate block (option: ABORT_ON_FAIL_EN)
module gate_bist_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter bit INVERT        = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       p1a,
    output logic       p1b,
    output logic       p1c,
    output logic       p1d,
    output logic       p2a,
    output logic       p2b,
    output logic       p2c,
    output logic       p2d,
    input  logic       p1y,
    input  logic       p2y,
    output logic [8:0] err_cnt1,
    output logic [8:0] err_cnt2,
    output logic       fail_valid,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] vec;
    logic [3:0] settle;
    logic       exp1;
    logic       exp2;
    logic       mis1;
    logic       mis2;
    logic       any_mis;
    logic       last_settle;

    assign exp1        = (&vec[3:0]) ^ INVERT;
    assign exp2        = (&vec[7:4]) ^ INVERT;
    assign mis1        = (p1y != exp1);
    assign mis2        = (p2y != exp2);
    assign any_mis     = mis1 | mis2;
    assign last_settle = (settle == 4'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = APPLY;
            APPLY:      if (last_settle) state_nxt = SAMPLE;
            SAMPLE: begin
                if (vec == 8'hFF) begin
                    state_nxt = DONE;
`ifdef ABORT_ON_FAIL_EN
                end else if (any_mis) begin
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = APPLY;
                end
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: vector, settle timer, error counters, first-fail capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= '0;
            settle     <= '0;
            err_cnt1   <= '0;
            err_cnt2   <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec        <= '0;
                        settle     <= '0;
                        err_cnt1   <= '0;
                        err_cnt2   <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                    end
                end
                APPLY: settle <= settle + 4'd1;
                SAMPLE: begin
                    if (mis1 && err_cnt1 != 9'd256) err_cnt1 <= err_cnt1 + 9'd1;
                    if (mis2 && err_cnt2 != 9'd256) err_cnt2 <= err_cnt2 + 9'd1;
                    if (any_mis && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                    end
                    if (vec != 8'hFF) vec <= vec + 8'd1;
                    settle <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state == APPLY) || (state == SAMPLE);
        done = (state == DONE);
        pass = done && (err_cnt1 == 9'd0) && (err_cnt2 == 9'd0);
        {p2a, p2b, p2c, p2d, p1a, p1b, p1c, p1d} = busy ? vec : 8'h00;
    end

endmodule
